// File: rtl/vga_pkg.sv
// Shared types and timing presets for the VGA raster generator.
// Axis descriptions are four phase lengths plus sync polarity.
package vga_pkg;

    localparam int VGA_W = 12;

    typedef logic [VGA_W-1:0] coord_t;
    typedef logic [VGA_W+1:0] total_t;

    typedef struct packed {
        coord_t active;
        coord_t fp;
        coord_t sync;
        coord_t bp;
        logic   pol;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam vga_timing_t TIMING_800X600_72 = '{
        h: '{
            active: 12'd800,
            fp:     12'd56,
            sync:   12'd120,
            bp:     12'd64,
            pol:    1'b1
        },
        v: '{
            active: 12'd600,
            fp:     12'd37,
            sync:   12'd6,
            bp:     12'd23,
            pol:    1'b1
        }
    };

    localparam vga_timing_t TIMING_640X480_60 = '{
        h: '{
            active: 12'd640,
            fp:     12'd16,
            sync:   12'd96,
            bp:     12'd48,
            pol:    1'b0
        },
        v: '{
            active: 12'd480,
            fp:     12'd10,
            sync:   12'd2,
            bp:     12'd33,
            pol:    1'b0
        }
    };

    // Two guard bits so an oversized sum is still visible to validation.
    function automatic total_t axis_total(input vga_axis_t a);
        return {2'b00, a.active}
             + {2'b00, a.fp}
             + {2'b00, a.sync}
             + {2'b00, a.bp};
    endfunction

    function automatic logic axis_valid(input vga_axis_t a);
        total_t lim;
        lim = {2'b00, {VGA_W{1'b1}}};
        return (a.active != '0)
            && (a.sync != '0)
            && (axis_total(a) <= lim);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with terminal, active and sync flags.
// The vertical instance is enabled by the horizontal terminal count.
module vga_axis_counter
    import vga_pkg::*;
(
    input  logic      Clock,
    input  logic      Reset,
    input  vga_axis_t axis,
    input  logic      en,
    output coord_t    count,
    output logic      wrap,
    output logic      active,
    output logic      sync
);

    total_t total;
    total_t sync_lo;
    total_t sync_hi;
    total_t cnt_x;

    always_comb begin
        total   = axis_total(axis);
        sync_lo = {2'b00, axis.active}
                + {2'b00, axis.fp};
        sync_hi = sync_lo + {2'b00, axis.sync};
        cnt_x   = {2'b00, count};
    end

    assign wrap   = (cnt_x == total - 1'b1);
    assign active = (count < axis.active);
    assign sync   = (cnt_x >= sync_lo)
                 && (cnt_x < sync_hi);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-reconfigurable VGA timing generator with shadowed timing set.
// A validated write is held in the shadow set until the frame boundary.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int W        = VGA_W,
    parameter int H_ACTIVE = int'(TIMING_800X600_72.h.active),
    parameter int H_FP     = int'(TIMING_800X600_72.h.fp),
    parameter int H_SYNC   = int'(TIMING_800X600_72.h.sync),
    parameter int H_BP     = int'(TIMING_800X600_72.h.bp),
    parameter int V_ACTIVE = int'(TIMING_800X600_72.v.active),
    parameter int V_FP     = int'(TIMING_800X600_72.v.fp),
    parameter int V_SYNC   = int'(TIMING_800X600_72.v.sync),
    parameter int V_BP     = int'(TIMING_800X600_72.v.bp),
    parameter bit H_POL    = TIMING_800X600_72.h.pol,
    parameter bit V_POL    = TIMING_800X600_72.v.pol
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_h_active,
    input  logic [W-1:0] cfg_h_fp,
    input  logic [W-1:0] cfg_h_sync,
    input  logic [W-1:0] cfg_h_bp,
    input  logic [W-1:0] cfg_v_active,
    input  logic [W-1:0] cfg_v_fp,
    input  logic [W-1:0] cfg_v_sync,
    input  logic [W-1:0] cfg_v_bp,
    input  logic         cfg_h_pol,
    input  logic         cfg_v_pol,
    output logic         cfg_pending,
    output logic         cfg_err,
    output logic         hSync,
    output logic         vSync,
    output logic         sync_n,
    output logic         blank_n,
    output logic [W-1:0] nextX,
    output logic [W-1:0] nextY,
    output logic         line_start,
    output logic         frame_start
);

    localparam vga_timing_t RESET_SET = '{
        h: '{
            active: coord_t'(H_ACTIVE),
            fp:     coord_t'(H_FP),
            sync:   coord_t'(H_SYNC),
            bp:     coord_t'(H_BP),
            pol:    H_POL
        },
        v: '{
            active: coord_t'(V_ACTIVE),
            fp:     coord_t'(V_FP),
            sync:   coord_t'(V_SYNC),
            bp:     coord_t'(V_BP),
            pol:    V_POL
        }
    };

    vga_timing_t live;
    vga_timing_t shadow;
    vga_timing_t cfg_in;

    logic   cfg_ok;
    logic   boundary;
    logic   in_active;

    coord_t h_count;
    coord_t v_count;
    logic   h_wrap;
    logic   v_wrap;
    logic   h_act;
    logic   v_act;
    logic   h_sync_ph;
    logic   v_sync_ph;

    always_comb begin
        cfg_in.h.active = coord_t'(cfg_h_active);
        cfg_in.h.fp     = coord_t'(cfg_h_fp);
        cfg_in.h.sync   = coord_t'(cfg_h_sync);
        cfg_in.h.bp     = coord_t'(cfg_h_bp);
        cfg_in.h.pol    = cfg_h_pol;
        cfg_in.v.active = coord_t'(cfg_v_active);
        cfg_in.v.fp     = coord_t'(cfg_v_fp);
        cfg_in.v.sync   = coord_t'(cfg_v_sync);
        cfg_in.v.bp     = coord_t'(cfg_v_bp);
        cfg_in.v.pol    = cfg_v_pol;
    end

    assign cfg_ok = axis_valid(cfg_in.h)
                 && axis_valid(cfg_in.v);

    assign boundary  = h_wrap && v_wrap;
    assign in_active = h_act && v_act;

    vga_axis_counter u_h (
        .Clock  (Clock),
        .Reset  (Reset),
        .axis   (live.h),
        .en     (1'b1),
        .count  (h_count),
        .wrap   (h_wrap),
        .active (h_act),
        .sync   (h_sync_ph)
    );

    vga_axis_counter u_v (
        .Clock  (Clock),
        .Reset  (Reset),
        .axis   (live.v),
        .en     (h_wrap),
        .count  (v_count),
        .wrap   (v_wrap),
        .active (v_act),
        .sync   (v_sync_ph)
    );

    // A write on the boundary cycle lands after the old shadow is applied.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            live        <= RESET_SET;
            shadow      <= RESET_SET;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (boundary && cfg_pending) begin
                live <= shadow;
            end
            if (cfg_we && cfg_ok) begin
                shadow      <= cfg_in;
                cfg_pending <= 1'b1;
            end else if (boundary) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hSync       <= ~H_POL;
            vSync       <= ~V_POL;
            sync_n      <= 1'b1;
            blank_n     <= 1'b0;
            nextX       <= '0;
            nextY       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hSync       <= h_sync_ph ? live.h.pol
                                     : ~live.h.pol;
            vSync       <= v_sync_ph ? live.v.pol
                                     : ~live.v.pol;
            sync_n      <= ~(h_sync_ph && v_sync_ph);
            blank_n     <= in_active;
            nextX       <= in_active ? W'(h_count) : '0;
            nextY       <= in_active ? W'(v_count) : '0;
            line_start  <= (h_count == '0);
            frame_start <= (h_count == '0)
                        && (v_count == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: cycle-level reference model plus
// table-driven write checks and hand-measured line/frame periods.
module tb_vga_timing_gen;

    localparam int W = 12;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         cfg_we = 1'b0;
    logic [W-1:0] cfg_h_active = '0;
    logic [W-1:0] cfg_h_fp = '0;
    logic [W-1:0] cfg_h_sync = '0;
    logic [W-1:0] cfg_h_bp = '0;
    logic [W-1:0] cfg_v_active = '0;
    logic [W-1:0] cfg_v_fp = '0;
    logic [W-1:0] cfg_v_sync = '0;
    logic [W-1:0] cfg_v_bp = '0;
    logic         cfg_h_pol = 1'b0;
    logic         cfg_v_pol = 1'b0;
    logic         cfg_pending;
    logic         cfg_err;
    logic         hSync;
    logic         vSync;
    logic         sync_n;
    logic         blank_n;
    logic [W-1:0] nextX;
    logic [W-1:0] nextY;
    logic         line_start;
    logic         frame_start;

    always #5 Clock = ~Clock;

    // Short vertical reset timing keeps frames at 1040 x 10 cycles.
    vga_timing_gen #(
        .W(W),
        .H_ACTIVE(800), .H_FP(56), .H_SYNC(120), .H_BP(64),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0)
    ) dut (
        .Clock(Clock), .Reset(Reset), .cfg_we(cfg_we),
        .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp),
        .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp),
        .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_h_pol(cfg_h_pol), .cfg_v_pol(cfg_v_pol),
        .cfg_pending(cfg_pending), .cfg_err(cfg_err),
        .hSync(hSync), .vSync(vSync), .sync_n(sync_n),
        .blank_n(blank_n), .nextX(nextX), .nextY(nextY),
        .line_start(line_start), .frame_start(frame_start)
    );

    typedef struct {
        int a;
        int fp;
        int s;
        int bp;
        bit pol;
    } axis_m;

    typedef struct {
        axis_m h;
        axis_m v;
    } cfg_m;

    typedef struct {
        cfg_m c;
        bit   err;
        bit   pend;
    } vec_t;

    cfg_m        dflt;
    cfg_m        idle;
    cfg_m        m_live;
    cfg_m        m_shadow;
    bit          m_pend;
    int          mh;
    int          mv;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] exp_vec;
    vec_t        vecs[7];
    string       vnames[7];

    function automatic cfg_m mk(
        input int ha, input int hf, input int hs, input int hb, input bit hp,
        input int va, input int vf, input int vs, input int vb, input bit vp
    );
        cfg_m c;
        c.h.a = ha; c.h.fp = hf; c.h.s = hs; c.h.bp = hb; c.h.pol = hp;
        c.v.a = va; c.v.fp = vf; c.v.s = vs; c.v.bp = vb; c.v.pol = vp;
        return c;
    endfunction

    function automatic int tot(input axis_m a);
        return a.a + a.fp + a.s + a.bp;
    endfunction

    function automatic bit ok_axis(input axis_m a);
        return a.a >= 1 && a.s >= 1 && tot(a) <= 4095;
    endfunction

    function automatic bit insync(input int n, input axis_m a);
        return n >= a.a + a.fp && n < a.a + a.fp + a.s;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h, want %h",
                     name, cyc, got, want);
        end
    endtask

    task automatic drive(input bit we, input cfg_m c);
        cfg_we       = we;
        cfg_h_active = W'(c.h.a);
        cfg_h_fp     = W'(c.h.fp);
        cfg_h_sync   = W'(c.h.s);
        cfg_h_bp     = W'(c.h.bp);
        cfg_h_pol    = c.h.pol;
        cfg_v_active = W'(c.v.a);
        cfg_v_fp     = W'(c.v.fp);
        cfg_v_sync   = W'(c.v.s);
        cfg_v_bp     = W'(c.v.bp);
        cfg_v_pol    = c.v.pol;
    endtask

    // One clock: drive, step the reference model, compare all outputs.
    task automatic tick(input bit rst, input bit we, input cfg_m c);
        bit hsy, vsy, bn, err, bnd, hl, hs, vs;
        int oh, ov;
        Reset = rst;
        drive(we, c);
        @(posedge Clock);
        cyc++;
        if (rst) begin
            mh = 0; mv = 0;
            m_live = dflt; m_shadow = dflt; m_pend = 0;
            exp_vec = {!dflt.h.pol, !dflt.v.pol, 1'b1, 1'b0,
                       12'd0, 12'd0, 4'b0000};
        end else begin
            oh  = mh; ov = mv;
            hsy = insync(oh, m_live.h);
            vsy = insync(ov, m_live.v);
            hs  = hsy ? m_live.h.pol : !m_live.h.pol;
            vs  = vsy ? m_live.v.pol : !m_live.v.pol;
            bn  = oh < m_live.h.a && ov < m_live.v.a;
            err = we && !(ok_axis(c.h) && ok_axis(c.v));
            hl  = oh == tot(m_live.h) - 1;
            bnd = hl && ov == tot(m_live.v) - 1;
            mh  = hl ? 0 : oh + 1;
            mv  = hl ? (bnd ? 0 : ov + 1) : ov;
            if (bnd && m_pend) begin
                m_live = m_shadow;
                m_pend = 0;
            end
            if (we && !err) begin
                m_shadow = c;
                m_pend   = 1;
            end
            exp_vec = {hs, vs, !(hsy && vsy), bn,
                       12'(bn ? oh : 0), 12'(bn ? ov : 0),
                       oh == 0, oh == 0 && ov == 0, err, m_pend};
        end
        #1;
        check("outputs", {hSync, vSync, sync_n, blank_n, nextX, nextY,
                          line_start, frame_start, cfg_err, cfg_pending},
              exp_vec);
    endtask

    task automatic run(input int n);
        repeat (n) tick(0, 0, idle);
    endtask

    task automatic do_reset(input int n);
        repeat (n) tick(1, 0, idle);
        tick(0, 0, idle);
    endtask

    task automatic wait_fs(output int waited);
        waited = 0;
        do begin
            tick(0, 0, idle);
            waited++;
        end while (!frame_start && waited < 30000);
        if (!frame_start) begin
            n_bad++;
            $display("FAIL frame_start timeout cycle %0d", cyc);
        end
    endtask

    // Entered with line_start visible, i.e. outputs showing hCount 0.
    task automatic measure_line(input bit pol, output int period,
                                output int s0, output int slen);
        period = 0; s0 = -1; slen = 0;
        do begin
            tick(0, 0, idle);
            period++;
            if (!line_start && hSync == pol) begin
                if (s0 < 0) s0 = period;
                slen++;
            end
        end while (!line_start && period < 5000);
    endtask

    task automatic check_line(input string tag, input bit pol,
                              input int per, input int st, input int len);
        int p, s, l;
        measure_line(pol, p, s, l);
        check({tag, " line period"}, p, per);
        check({tag, " sync start"}, s, st);
        check({tag, " sync length"}, l, len);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        int   ha;
        cfg_m a, b, c;

        dflt = mk(800, 56, 120, 64, 1, 6, 1, 2, 1, 0);
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs[0] = '{mk(40, 2, 0, 2, 1, 6, 1, 1, 1, 1), 1, 0};
        vecs[1] = '{mk(40, 2, 4, 2, 1, 0, 1, 1, 1, 1), 1, 0};
        vecs[2] = '{mk(4000, 50, 40, 10, 1, 6, 1, 1, 1, 1), 1, 0};
        vecs[3] = '{mk(4000, 50, 40, 5, 1, 6, 1, 1, 1, 1), 0, 1};
        vecs[4] = '{mk(40, 2, 4, 2, 1, 6, 1, 0, 1, 1), 1, 1};
        vecs[5] = '{mk(10, 0, 2, 0, 1, 4, 0, 1, 0, 0), 0, 1};
        vecs[6] = '{mk(40, 2, 4, 2, 1, 4000, 90, 2, 4, 1), 1, 1};
        vnames = '{"h_sync0", "v_active0", "h_total4100", "h_total4095",
                   "v_sync0", "zero_porch", "v_total4096"};

        // Reset defaults: first cycle shows (0,0) with both strobes.
        do_reset(3);
        check("first blank_n", blank_n, 1);
        check("first frame_start", frame_start, 1);
        begin
            int p, s, l, xl;
            measure_line(1'b1, p, s, l);
            check("dflt line period", p, 1040);
            check("dflt hsync start", s, 856);
            check("dflt hsync length", l, 120);
            wait_fs(xl);
            check("dflt frame period", xl + 1040, 10400);
        end

        // Write validation table.
        do_reset(2);
        for (int i = 0; i < 7; i++) begin
            tick(0, 1, vecs[i].c);
            check({vnames[i], " err"}, cfg_err, vecs[i].err);
            check({vnames[i], " pending"}, cfg_pending, vecs[i].pend);
            tick(0, 0, idle);
            check({vnames[i], " err clear"}, cfg_err, 0);
        end

        // Mid-frame reconfiguration to 640-wide, 15-line frame.
        do_reset(2);
        run(3 * 1040 + 400);
        tick(0, 1, mk(640, 16, 96, 48, 0, 8, 2, 2, 3, 0));
        check("reconf pending", cfg_pending, 1);
        wait_fs(w);
        check_line("640", 1'b0, 800, 656, 96);
        wait_fs(w);
        check("640 frame period", w + 800, 12000);

        // Boundary collision: A pending, B written on the boundary.
        do_reset(2);
        a = mk(20, 2, 3, 2, 1, 5, 1, 1, 1, 1);
        b = mk(10, 0, 2, 0, 1, 4, 0, 1, 0, 0);
        tick(0, 1, a);
        w = 0;
        while (!(mh == tot(m_live.h) - 1 && mv == tot(m_live.v) - 1)
               && w < 20000) begin
            tick(0, 0, idle);
            w++;
        end
        tick(0, 1, b);
        check("collision pending", cfg_pending, 1);
        wait_fs(w);
        check_line("A", 1'b1, 27, 22, 3);
        wait_fs(w);
        check("A frame period", w + 27, 216);
        check("B applied pending", cfg_pending, 0);
        check_line("B zero porch", 1'b1, 12, 10, 2);

        // Random writes against the reference model.
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                ha = int'($urandom_range(0, 24));
                if ($urandom_range(0, 15) == 0) ha = 4090;
                c = mk(ha, int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 4)),
                       1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 6)),
                       int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)));
                tick(0, 1, c);
            end else begin
                tick(0, 0, idle);
            end
        end

        // Reset with a write pending: defaults return, write discarded.
        tick(0, 1, mk(30, 2, 4, 2, 0, 5, 1, 1, 1, 1));
        run(5);
        do_reset(2);
        check("post reset pending", cfg_pending, 0);
        check("post reset frame_start", frame_start, 1);
        check_line("post reset", 1'b1, 1040, 856, 120);
        run(10400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
